aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Iterative AES encryption controller that drives the existing combinational `diffusion` block (ShiftRows + MixColumns) one round per clock. It loads a 128-bit plaintext, performs the initial AddRoundKey, runs NUM_ROUNDS-1 full rounds and one final round without MixColumns, then presents the ciphertext with a one-cycle valid pulse. Round keys come from an external key-schedule store indexed by `round_idx`.

## Interface
- NUM_ROUNDS, 10, total AES rounds; 10 for AES-128, 12 and 14 legal for 192/256 keys supplied externally.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock; all state is cleared on the edge where reset=1.
- start  input  1  request to encrypt `block_in`; accepted only when `ready`=1.
- block_in  input  128  plaintext, FIPS-197 byte order (bits 127:120 = byte 0).
- ready  output  1  high only in IDLE.
- round_idx  output  4  current round number (0..NUM_ROUNDS); key store responds combinationally.
- round_key  input  128  round key for `round_idx`, valid in the same cycle.
- out_valid  output  1  one-cycle pulse; `block_out` holds the ciphertext.
- block_out  output  128  ciphertext; stable from `out_valid` until the next accepted start.

## Operation
- State byte mapping: state[r][c] = block bits [127-8*(4c+r) -: 8] (column-major, FIPS-197). Same mapping for round_key and block_out.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: ready=1, round_idx=0. On start=1: state <= block_in ^ round_key (key 0), rnd <= 1, go to ROUND.
- ROUND: round_idx=rnd; state <= MixColumns(ShiftRows(SubBytes(state))) ^ round_key, taken from `diffusion_out`; rnd <= rnd+1; go to FINAL when rnd == NUM_ROUNDS-1, else stay.
- FINAL: round_idx=NUM_ROUNDS; state <= ShiftRows(SubBytes(state)) ^ round_key, taken from `srows_out`; go to DONE.
- DONE: out_valid=1, block_out=state; round_idx=0; go to IDLE unconditionally. start is ignored in DONE.
- start while ready=0 is ignored. It is not queued.
- block_in is sampled only on the accepting edge. Later changes have no effect.
- rnd counter width is 4 bits. It never exceeds NUM_ROUNDS and does not wrap.
- Reset at any point, including mid-encryption: FSM enters IDLE, state and block_out are cleared to 0, rnd=0, out_valid=0. No partial result is emitted.
- Reset and start in the same cycle: reset wins and start is dropped.

## Timing
- Reset values: ready=1 (IDLE), out_valid=0, block_out=128'h0, round_idx=0.
- Start accepted at edge T: ROUND occupies cycles T+1..T+NUM_ROUNDS-1, FINAL occupies T+NUM_ROUNDS, out_valid=1 during cycle T+NUM_ROUNDS+1.
- Latency with NUM_ROUNDS=10 is 11 cycles from the accepting edge to out_valid. ready returns in cycle T+NUM_ROUNDS+2.
- Throughput is one block per NUM_ROUNDS+2 cycles. A start held continuously is re-accepted at the first IDLE cycle.
- Combinational paths: round_idx to round_key to state D input. Per cycle: one SubBytes, one diffusion and one XOR layer. No combinational path from inputs to outputs.

## Structure
- The shared package `aes_pkg` holds:
  - the byte typedef;
  - the 4x4 state typedef `aes_state_t`, matching the diffusion port shape;
  - the FSM enum;
  - the block/state pack and unpack functions;
  - the default NUM_ROUNDS constant.
- New sub-module `aes_sub_bytes`: combinational 16-way S-box layer on `aes_state_t`, with the S-box table held in `aes_pkg`.
- `diffusion` is instantiated unmodified. Its `srows_out` serves the final round and its `diffusion_out` serves full rounds.

## Test plan
- Reset check: hold reset 3 cycles, then observe ready=1, out_valid=0, block_out=0, round_idx=0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, with round keys from the bench key-schedule model. Start with 3243f6a8885a308d313198a2e0370734, then expect out_valid exactly 11 cycles later with 3925841d02dc09fbdc118597196a0b32. round_idx must step 0,1..10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, expected ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Busy ignore: pulse start with a different block_in at cycles T+3 and T+11 (DONE). The first result must be unchanged, and no second encryption may start without a start in IDLE.
- Mid-run reset: assert reset at cycle T+5, then check IDLE with block_out=0 next cycle and no out_valid. A following start with the App. B vector yields the correct ciphertext.
- Back-to-back: hold start high with the C.1 then App. B vectors. Expect out_valid pulses 12 cycles apart, both ciphertexts correct, and block_out holding between the pulses.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, S-box table, FSM enum and block/state conversion helpers
// used by the round sequencer and its combinational datapath blocks.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS_DEFAULT = 10;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:3][0:3] aes_state_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} seq_state_e;

    // Byte 0 of the table sits in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t x);
        return byte_t'(SBOX_TABLE >> {8'(8'hff - x), 3'b000});
    endfunction

    // Column-major byte mapping: byte 4c+r of the block is state[r][c].
    function automatic aes_state_t to_state(input logic [127:0] blk);
        aes_state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = blk[127 - 8*(4*c + r) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input aes_state_t s);
        logic [127:0] blk;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                blk[127 - 8*(4*c + r) -: 8] = s[r][c];
        return blk;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Encryption request/response and key-store lookup bundle of the round sequencer.
interface aes_round_sequencer_if;
    logic         start;
    logic [127:0] block_in;
    logic         ready;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic [127:0] block_out;

    modport master (output start, block_in, round_key,
                    input  ready, round_idx, out_valid, block_out);
    modport slave  (input  start, block_in, round_key,
                    output ready, round_idx, out_valid, block_out);
endinterface

// File: rtl/aes_sub_bytes.sv
// Combinational SubBytes layer: the S-box applied to all 16 state bytes.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  aes_state_t state,
    output aes_state_t subbed
);

    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                subbed[r][c] = sbox(state[r][c]);
    end

endmodule

// File: rtl/diffusion.sv
// Combinational ShiftRows, and ShiftRows followed by MixColumns, on one state.
module diffusion
    import aes_pkg::*;
(
    input  aes_state_t state,
    output aes_state_t srows_out,
    output aes_state_t diffusion_out
);

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                srows_out[r][c] = state[r][(c + r) % 4];
    end

    // MixColumns: each column times the fixed {02,03,01,01} circulant.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            diffusion_out[0][c] = xtime(srows_out[0][c]) ^ xtime(srows_out[1][c]) ^ srows_out[1][c]
                                ^ srows_out[2][c] ^ srows_out[3][c];
            diffusion_out[1][c] = srows_out[0][c] ^ xtime(srows_out[1][c]) ^ xtime(srows_out[2][c])
                                ^ srows_out[2][c] ^ srows_out[3][c];
            diffusion_out[2][c] = srows_out[0][c] ^ srows_out[1][c] ^ xtime(srows_out[2][c])
                                ^ xtime(srows_out[3][c]) ^ srows_out[3][c];
            diffusion_out[3][c] = xtime(srows_out[0][c]) ^ srows_out[0][c] ^ srows_out[1][c]
                                ^ srows_out[2][c] ^ xtime(srows_out[3][c]);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: one round per clock through SubBytes and
// the diffusion block, with round keys fetched from an external store by round_idx.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_round_sequencer_if.slave   bus
);

    localparam logic [3:0] LAST_FULL = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_IDX = 4'(NUM_ROUNDS);

    seq_state_e   fsm_q, fsm_n;
    logic [3:0]   rnd_q, rnd_n;
    logic [127:0] st_q, st_n;
    logic         ready_q, ready_n;
    logic         out_valid_q, out_valid_n;
    logic [3:0]   idx_q, idx_n;
    logic [127:0] block_out_q, block_out_n;

    aes_state_t cur_state, sub_state, srows, mixed;

    assign cur_state = to_state(st_q);

    aes_sub_bytes u_sub_bytes (
        .state  (cur_state),
        .subbed (sub_state)
    );

    diffusion u_diffusion (
        .state         (sub_state),
        .srows_out     (srows),
        .diffusion_out (mixed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            st_q        <= 128'h0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            idx_q       <= 4'd0;
            block_out_q <= 128'h0;
        end else begin
            fsm_q       <= fsm_n;
            rnd_q       <= rnd_n;
            st_q        <= st_n;
            ready_q     <= ready_n;
            out_valid_q <= out_valid_n;
            idx_q       <= idx_n;
            block_out_q <= block_out_n;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        fsm_n       = fsm_q;
        rnd_n       = rnd_q;
        st_n        = st_q;
        ready_n     = 1'b0;
        out_valid_n = 1'b0;
        idx_n       = 4'd0;
        block_out_n = block_out_q;
        unique case (fsm_q)
            IDLE: begin
                ready_n = 1'b1;
                if (bus.start) begin
                    st_n    = bus.block_in ^ bus.round_key;
                    rnd_n   = 4'd1;
                    idx_n   = 4'd1;
                    ready_n = 1'b0;
                    fsm_n   = ROUND;
                end
            end
            ROUND: begin
                st_n  = from_state(mixed) ^ bus.round_key;
                rnd_n = rnd_q + 4'd1;
                if (rnd_q == LAST_FULL) begin
                    fsm_n = FINAL;
                    idx_n = FINAL_IDX;
                end else begin
                    idx_n = rnd_q + 4'd1;
                end
            end
            FINAL: begin
                st_n        = from_state(srows) ^ bus.round_key;
                block_out_n = from_state(srows) ^ bus.round_key;
                out_valid_n = 1'b1;
                fsm_n       = DONE;
            end
            DONE: begin
                rnd_n   = 4'd0;
                ready_n = 1'b1;
                fsm_n   = IDLE;
            end
            default: begin
                ready_n = 1'b1;
                fsm_n   = IDLE;
            end
        endcase
    end

    assign bus.ready     = ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.round_idx = idx_q;
    assign bus.block_out = block_out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: FIPS-197 vectors, busy-start rejection,
// mid-run reset, reset/start collision and back-to-back encryption.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] rk [16];
    vec_t vecs [3];

    always #5 clk = ~clk;

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Key store answers combinationally from round_idx.
    assign bus.round_key = rk[bus.round_idx];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AES-128 key expansion into rk[0..10].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        expand(v.key);
        check({tag, "_ready_pre"}, 128'(bus.ready), 128'd1);
        bus.block_in = v.pt;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.block_in = '1;
        for (int k = 1; k <= 10; k++) begin
            check({tag, "_round_idx"}, 128'(bus.round_idx), 128'(k));
            check({tag, "_valid_early"}, 128'(bus.out_valid), 128'd0);
            step();
        end
        check({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
        check({tag, "_ct"}, bus.block_out, v.ct);
        check({tag, "_idx_done"}, 128'(bus.round_idx), 128'd0);
        step();
        check({tag, "_valid_pulse"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_ready_post"}, 128'(bus.ready), 128'd1);
        check({tag, "_ct_hold"}, bus.block_out, v.ct);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h0,
                    pt:  128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.block_in = 128'h0;
        expand(vecs[0].key);
        repeat (3) step();
        reset = 1'b0;
        check("rst_ready", 128'(bus.ready), 128'd1);
        check("rst_valid", 128'(bus.out_valid), 128'd0);
        check("rst_block_out", bus.block_out, 128'h0);
        check("rst_round_idx", 128'(bus.round_idx), 128'd0);

        for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Starts while busy and while in DONE are dropped.
        expand(vecs[0].key);
        bus.block_in = vecs[0].pt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.block_in = vecs[1].pt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        check("busy_valid", 128'(bus.out_valid), 128'd1);
        check("busy_ct", bus.block_out, vecs[0].ct);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_ready", 128'(bus.ready), 128'd1);
        for (int k = 0; k < 14; k++) begin
            check("busy_no_restart", 128'({bus.out_valid, bus.round_idx}), 128'd0);
            step();
        end
        check("busy_ct_hold", bus.block_out, vecs[0].ct);

        // Mid-run reset clears state and emits nothing.
        bus.block_in = vecs[0].pt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_ready", 128'(bus.ready), 128'd1);
        check("mid_rst_block_out", bus.block_out, 128'h0);
        check("mid_rst_valid", 128'(bus.out_valid), 128'd0);
        check("mid_rst_idx", 128'(bus.round_idx), 128'd0);
        for (int k = 0; k < 14; k++) begin
            check("mid_rst_quiet", 128'(bus.out_valid), 128'd0);
            step();
        end
        run_vec(vecs[0], "after_rst");

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        bus.start = 1'b1;
        bus.block_in = vecs[0].pt;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_start_ready", 128'(bus.ready), 128'd1);
        step();
        check("rst_start_idle", 128'({bus.ready, bus.round_idx}), 128'h10);

        // Back-to-back: start held high across two encryptions.
        expand(vecs[1].key);
        bus.block_in = vecs[1].pt;
        bus.start = 1'b1;
        step();
        bus.block_in = vecs[0].pt;
        for (int k = 1; k <= 10; k++) begin
            check("b2b_first_wait", 128'(bus.out_valid), 128'd0);
            step();
        end
        check("b2b_first_valid", 128'(bus.out_valid), 128'd1);
        check("b2b_first_ct", bus.block_out, vecs[1].ct);
        expand(vecs[0].key);
        step();
        check("b2b_idle_ready", 128'(bus.ready), 128'd1);
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check("b2b_second_idx", 128'(bus.round_idx), 128'(k));
            check("b2b_hold", bus.block_out, vecs[1].ct);
            check("b2b_second_wait", 128'(bus.out_valid), 128'd0);
            step();
        end
        check("b2b_second_valid", 128'(bus.out_valid), 128'd1);
        check("b2b_second_ct", bus.block_out, vecs[0].ct);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
